// File: rtl/sram_byte_bridge_pkg.sv
// sram_byte_bridge_pkg: shared state type, lane ids and byte-lane helper for the SRAM byte bridge
package sram_byte_bridge_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} sram_state_t;
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;
   function automatic logic [7:0] lane_byte(input logic [15:0] w, input logic lane);
      return lane ? w[15:8] : w[7:0];
   endfunction
endpackage

// File: rtl/sram_byte_bridge_if.sv
// sram_byte_bridge_if: arbitrated 16-bit word bus between memory arbiter and SRAM bridge
interface sram_byte_bridge_if;
   logic [18:0] m_addr;
   logic [15:0] m_data_out;
   logic [15:0] m_data_in;
   logic        m_access;
   logic        m_ack;
   logic        m_wr_en;
   logic [1:0]  m_bytesel;
   modport master(output m_addr, m_data_out, m_access, m_wr_en, m_bytesel, input m_data_in, m_ack);
   modport slave(input m_addr, m_data_out, m_access, m_wr_en, m_bytesel, output m_data_in, m_ack);
endinterface

// File: rtl/sram_byte_bridge_wait.sv
// sram_wait_counter: strobe-length down-counter, done while the count sits at zero
module sram_wait_counter #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_load,
   output logic o_done
);
   localparam int W = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
   logic [W-1:0] r_cnt;
   // load on SETUP so the first STROBE cycle sees WAIT_CYCLES-1, then count down to zero
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else if (i_load) r_cnt <= W'(WAIT_CYCLES - 1);
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/sram_byte_bridge.sv
// sram_byte_bridge: runs 16-bit word requests as one or two byte cycles on an async 8-bit SRAM
module sram_byte_bridge
   import sram_byte_bridge_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_byte_bridge_if.slave     m,
   output logic [19:0]           o_sram_addr,
   output logic [7:0]            o_sram_dq_o,
   input  logic [7:0]            i_sram_dq_i,
   output logic                  o_sram_dq_oe,
   output logic                  o_sram_ce_n,
   output logic                  o_sram_oe_n,
   output logic                  o_sram_we_n
);
   sram_state_t r_state;
   logic [18:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_data_in;
   logic [19:0] r_sram_addr;
   logic [7:0]  r_dq_o;
   logic        r_wr, r_sel_hi, r_lane, r_ack, r_dq_oe, r_ce_n, r_oe_n, r_we_n;
   logic        w_done, w_idle, w_accept, w_more, w_start, w_go_lane, w_go_wr;
   logic [18:0] w_go_addr;
   logic [15:0] w_go_data;

   sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk    (clk),
      .reset  (reset),
      .i_load (r_state == SETUP),
      .o_done (w_done)
   );

   // a lane cycle starts either from a fresh request or as the high lane following the low one
   assign w_idle    = (r_state == IDLE);
   assign w_accept  = w_idle && m.m_access && !r_ack;
   assign w_more    = (r_state == STROBE) && w_done && (r_lane == LANE_LO) && r_sel_hi;
   assign w_start   = (w_accept && (m.m_bytesel != 2'b00)) || w_more;
   assign w_go_lane = w_idle ? (m.m_bytesel[0] ? LANE_LO : LANE_HI) : LANE_HI;
   assign w_go_wr   = w_idle ? m.m_wr_en : r_wr;
   assign w_go_addr = w_idle ? m.m_addr : r_addr;
   assign w_go_data = w_idle ? m.m_data_out : r_wdata;

   // sequencer; all SRAM pins come straight from registers, the SETUP entry block overrides the case
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wr        <= 1'b0;
         r_sel_hi    <= 1'b0;
         r_lane      <= LANE_LO;
         r_ack       <= 1'b0;
         r_data_in   <= '0;
         r_sram_addr <= '0;
         r_dq_o      <= '0;
         r_dq_oe     <= 1'b0;
         r_ce_n      <= 1'b1;
         r_oe_n      <= 1'b1;
         r_we_n      <= 1'b1;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               r_addr   <= m.m_addr;
               r_wdata  <= m.m_data_out;
               r_wr     <= m.m_wr_en;
               r_sel_hi <= m.m_bytesel[1];
               if (!m.m_wr_en) r_data_in <= '0;
               if (m.m_bytesel == 2'b00) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
               end
            end
            SETUP: begin
               r_state <= STROBE;
               r_we_n  <= !r_wr;
            end
            STROBE: if (w_done) begin
               r_we_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               if (!r_wr && r_lane) r_data_in[15:8] <= i_sram_dq_i;
               if (!r_wr && !r_lane) r_data_in[7:0] <= i_sram_dq_i;
               r_state <= ACK;
               r_ack   <= 1'b1;
               r_ce_n  <= 1'b1;
            end
            ACK: begin
               r_state <= IDLE;
               r_dq_oe <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
         if (w_start) begin
            r_state     <= SETUP;
            r_ack       <= 1'b0;
            r_lane      <= w_go_lane;
            r_sram_addr <= {w_go_addr, w_go_lane};
            r_dq_o      <= lane_byte(w_go_data, w_go_lane);
            r_dq_oe     <= w_go_wr;
            r_ce_n      <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= w_go_wr;
         end
      end

   assign m.m_ack      = r_ack;
   assign m.m_data_in  = r_data_in;
   assign o_sram_addr  = r_sram_addr;
   assign o_sram_dq_o  = r_dq_o;
   assign o_sram_dq_oe = r_dq_oe;
   assign o_sram_ce_n  = r_ce_n;
   assign o_sram_oe_n  = r_oe_n;
   assign o_sram_we_n  = r_we_n;
endmodule

// File: tb/tb_sram_byte_bridge.sv
// tb_sram_byte_bridge: directed vector table plus multi-cycle sequences against behavioural SRAMs
module tb_sram_byte_bridge;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sram_byte_bridge_if bus();
   sram_byte_bridge_if bus3();

   logic [19:0] s_addr, s3_addr;
   logic [7:0]  s_dq_o, s_dq_i, s3_dq_o, s3_dq_i;
   logic        s_dq_oe, s_ce_n, s_oe_n, s_we_n, s3_dq_oe, s3_ce_n, s3_oe_n, s3_we_n;

   sram_byte_bridge #(.WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .m(bus.slave),
      .o_sram_addr(s_addr), .o_sram_dq_o(s_dq_o), .i_sram_dq_i(s_dq_i),
      .o_sram_dq_oe(s_dq_oe), .o_sram_ce_n(s_ce_n), .o_sram_oe_n(s_oe_n), .o_sram_we_n(s_we_n)
   );

   sram_byte_bridge #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .m(bus3.slave),
      .o_sram_addr(s3_addr), .o_sram_dq_o(s3_dq_o), .i_sram_dq_i(s3_dq_i),
      .o_sram_dq_oe(s3_dq_oe), .o_sram_ce_n(s3_ce_n), .o_sram_oe_n(s3_oe_n), .o_sram_we_n(s3_we_n)
   );

   logic [7:0] mem [0:255];
   logic [7:0] mem3 [0:255];
   logic       pre_en = 1'b0;
   logic [7:0] pre_a = '0, pre_d = '0;

   assign s_dq_i  = (!s_ce_n && !s_oe_n) ? mem[s_addr[7:0]] : 8'h00;
   assign s3_dq_i = (!s3_ce_n && !s3_oe_n) ? mem3[s3_addr[7:0]] : 8'h00;

   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      else if (!s_ce_n && !s_we_n && s_dq_oe) mem[s_addr[7:0]] <= s_dq_o;
   end

   always @(posedge clk) begin
      if (pre_en) mem3[pre_a] <= pre_d;
      else if (!s3_ce_n && !s3_we_n && s3_dq_oe) mem3[s3_addr[7:0]] <= s3_dq_o;
   end

   logic [19:0] p_addr = '0;
   logic [7:0]  p_dq = '0;
   int          viol = 0;
   always @(negedge clk) begin
      if (!reset && !s_we_n && (s_ce_n || !s_dq_oe || s_addr !== p_addr || s_dq_o !== p_dq)) viol <= viol + 1;
      p_addr <= s_addr;
      p_dq   <= s_dq_o;
   end

   typedef struct {
      logic        wr;
      logic [1:0]  sel;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [9];
   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pre_a = a;
      pre_d = d;
      pre_en = 1'b1;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic do_op(input vec_t v, input string nm);
      int lat;
      logic [1:0] seen;
      logic bad;
      logic [15:0] got;
      @(posedge clk);
      #1;
      bus.m_access = 1'b1;
      bus.m_wr_en = v.wr;
      bus.m_bytesel = v.sel;
      bus.m_addr = v.addr;
      bus.m_data_out = v.wdata;
      lat = 0;
      seen = 2'b00;
      bad = 1'b0;
      do begin
         @(posedge clk);
         #1 lat++;
         if (!s_ce_n) begin
            if (s_addr == {v.addr, 1'b0}) seen[0] = 1'b1;
            else if (s_addr == {v.addr, 1'b1}) seen[1] = 1'b1;
            else bad = 1'b1;
         end
      end while (!bus.m_ack && lat < 30);
      bus.m_access = 1'b0;
      check({nm, " latency"}, lat, v.lat);
      check({nm, " lanes"}, {bad, seen}, {1'b0, v.sel});
      got = v.wr ? {mem[{v.addr[6:0], 1'b1}], mem[{v.addr[6:0], 1'b0}]} : bus.m_data_in;
      check({nm, v.wr ? " memory" : " read data"}, got, v.exp);
      @(posedge clk);
      #1 check({nm, " ack width"}, bus.m_ack, 1'b0);
   endtask

   initial begin
      int n;
      int ce_cnt;
      logic ack_seen;
      bus.m_access = 1'b0; bus.m_wr_en = 1'b0; bus.m_bytesel = 2'b00; bus.m_addr = '0; bus.m_data_out = '0;
      bus3.m_access = 1'b0; bus3.m_wr_en = 1'b0; bus3.m_bytesel = 2'b00; bus3.m_addr = '0; bus3.m_data_out = '0;
      vecs[0] = '{1'b0, 2'b11, 19'h00010, 16'h0000, 16'h1234, 5};
      vecs[1] = '{1'b1, 2'b11, 19'h00008, 16'hBEEF, 16'hBEEF, 5};
      vecs[2] = '{1'b0, 2'b10, 19'h00001, 16'h0000, 16'hA500, 3};
      vecs[3] = '{1'b0, 2'b01, 19'h00001, 16'h0000, 16'h005A, 3};
      vecs[4] = '{1'b0, 2'b00, 19'h00010, 16'h0000, 16'h0000, 1};
      vecs[5] = '{1'b1, 2'b01, 19'h0000A, 16'h77C3, 16'h99C3, 3};
      vecs[6] = '{1'b1, 2'b10, 19'h0000B, 16'h6611, 16'h6644, 3};
      vecs[7] = '{1'b0, 2'b11, 19'h00008, 16'h0000, 16'hBEEF, 5};
      vecs[8] = '{1'b1, 2'b00, 19'h0000A, 16'hFFFF, 16'h99C3, 1};
      preload(8'h20, 8'h34);
      preload(8'h21, 8'h12);
      preload(8'h03, 8'hA5);
      preload(8'h02, 8'h5A);
      preload(8'h15, 8'h99);
      preload(8'h16, 8'h44);
      check("reset ack", bus.m_ack, 1'b0);
      check("reset data_in", bus.m_data_in, 16'h0000);
      check("reset addr", s_addr, 20'h00000);
      check("reset dq_o", s_dq_o, 8'h00);
      check("reset strobes", {s_dq_oe, s_ce_n, s_oe_n, s_we_n}, 4'b0111);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

      // write then read with m_access held through the ack cycle
      @(posedge clk);
      #1;
      bus.m_access = 1'b1; bus.m_wr_en = 1'b1; bus.m_bytesel = 2'b11; bus.m_addr = 19'h00030; bus.m_data_out = 16'hCAFE;
      n = 0;
      do begin @(posedge clk); #1 n++; end while (!bus.m_ack && n < 30);
      check("b2b write latency", n, 5);
      bus.m_wr_en = 1'b0;
      bus.m_data_out = 16'h0000;
      n = 0;
      do begin @(posedge clk); #1 n++; end while (!bus.m_ack && n < 30);
      bus.m_access = 1'b0;
      check("b2b read ack distance", n, 6);
      check("b2b read data", bus.m_data_in, 16'hCAFE);

      // reset asserted during the high-lane strobe of a word write
      @(posedge clk);
      #1;
      bus.m_access = 1'b1; bus.m_wr_en = 1'b1; bus.m_bytesel = 2'b11; bus.m_addr = 19'h00040; bus.m_data_out = 16'h1122;
      repeat (4) @(posedge clk);
      #1 check("rst hi strobe active", {s_we_n, s_addr}, {1'b0, 20'h00081});
      #2 reset = 1'b1;
      #1 check("rst pins async", {s_we_n, s_oe_n, s_ce_n, s_dq_oe, bus.m_ack}, 5'b11100);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.m_access = 1'b0;
      ack_seen = 1'b0;
      repeat (6) begin @(posedge clk); #1 if (bus.m_ack) ack_seen = 1'b1; end
      check("rst no ack", ack_seen, 1'b0);
      check("rst low lane written", mem[8'h80], 8'h22);
      do_op(vecs[7], "post-reset read");

      // WAIT_CYCLES=3 word read, access dropped and address changed mid-transaction
      preload(8'h20, 8'h34);
      preload(8'h21, 8'h12);
      @(posedge clk);
      #1;
      bus3.m_access = 1'b1; bus3.m_wr_en = 1'b0; bus3.m_bytesel = 2'b11; bus3.m_addr = 19'h00010;
      n = 0;
      ce_cnt = 0;
      do begin
         @(posedge clk);
         #1 n++;
         if (!s3_ce_n) ce_cnt++;
         if (n == 2) begin bus3.m_access = 1'b0; bus3.m_addr = 19'h00055; end
      end while (!bus3.m_ack && n < 30);
      check("wait3 latency", n, 9);
      check("wait3 read data", bus3.m_data_in, 16'h1234);
      check("wait3 ce cycles", ce_cnt, 8);
      check("we_n window violations", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
